// File: rtl/muldiv_pkg.sv
// Shared types and constants for the muldiv_seq multiply/divide sequencer.
// Optional signed support in the sequencer is controlled by MULDIV_SIGNED_EN.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MULHU = 3'd1,
    OP_DIVU  = 3'd2,
    OP_REMU  = 3'd3,
    OP_MULH  = 3'd4,
    OP_DIV   = 3'd5,
    OP_REM   = 3'd6,
    OP_RSVD  = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [3:0]  ALU_ADD   = 4'b0000;
  localparam logic [3:0]  ALU_SUB   = 4'b1000;
  localparam logic [31:0] DIVZERO_Q = 32'hFFFFFFFF;
  localparam logic [31:0] DIV_OVF_Q = 32'h80000000;

  // Divide-family ops use the restoring divider path.
  function automatic logic op_is_div(input muldiv_op_t op);
    return (op == OP_DIVU) || (op == OP_REMU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Remainder-family ops return the dividend on divide-by-zero.
  function automatic logic op_is_rem(input muldiv_op_t op);
    return (op == OP_REMU) || (op == OP_REM);
  endfunction

  // Result lives in the high register (P_hi / R) rather than the low one (L / Q).
  function automatic logic op_sel_hi(input muldiv_op_t op);
    return (op == OP_MULHU) || (op == OP_MULH) || (op == OP_REMU) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide. Drives the shared
// ALU operands and forms the next {hi, lo} register pair from the ALU result.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0] i_alu_out,
  output logic [WIDTH-1:0] o_alu_op1,
  output logic [WIDTH-1:0] o_alu_op2,
  output logic [3:0]       o_alu_ctrl,
  output logic [WIDTH-1:0] o_hi_nxt,
  output logic [WIDTH-1:0] o_lo_nxt
);

  logic [WIDTH:0] w_sh;
  logic           w_ge;
  logic           w_carry;

  assign w_sh    = {i_hi, i_lo[WIDTH-1]};
  assign w_ge    = w_sh[WIDTH] | (w_sh[WIDTH-1:0] >= i_mcand);
  assign w_carry = (i_alu_out < i_hi);

  // ALU request: subtract divisor from shifted remainder, or add multiplicand to P_hi.
  always_comb begin
    if (i_is_div) begin
      o_alu_ctrl = ALU_SUB;
      o_alu_op1  = w_sh[WIDTH-1:0];
      o_alu_op2  = i_mcand;
    end else begin
      o_alu_ctrl = ALU_ADD;
      o_alu_op1  = i_hi;
      o_alu_op2  = i_lo[0] ? i_mcand : '0;
    end
  end

  // Next register pair from the ALU result (kept apart from the request so no false loop forms).
  always_comb begin
    if (i_is_div) begin
      o_hi_nxt = w_ge ? i_alu_out : w_sh[WIDTH-1:0];
      o_lo_nxt = {i_lo[WIDTH-2:0], w_ge};
    end else begin
      o_hi_nxt = {w_carry, i_alu_out[WIDTH-1:1]};
      o_lo_nxt = {i_alu_out[0], i_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle RV32M multiply/divide sequencer borrowing the shared 32-bit ALU.
// Define MULDIV_SIGNED_EN to enable MULH/DIV/REM with sign capture, the FIX
// negation state and the DIV overflow shortcut; otherwise ops 4-6 run unsigned.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_divzero,
  output logic [WIDTH-1:0] alu_op1,
  output logic [WIDTH-1:0] alu_op2,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_out
);

  state_t           r_state;
  muldiv_op_t       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_result;
  logic             r_divzero;

  muldiv_op_t       w_op;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;
  logic             w_is_div;
  logic             w_in_is_div;
  logic [WIDTH-1:0] w_step_op1;
  logic [WIDTH-1:0] w_step_op2;
  logic [3:0]       w_step_ctrl;
  logic [WIDTH-1:0] w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;

`ifdef MULDIV_SIGNED_EN
  logic             r_sign;
  logic             w_sign;
  logic             w_ovf;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction
`endif

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign out_result  = r_result;
  assign out_divzero = r_divzero;
  assign w_is_div    = op_is_div(r_op);
  assign w_in_is_div = op_is_div(w_op);

  // Decode the incoming op and prepare operand magnitudes for the iteration core.
  always_comb begin
    w_op    = muldiv_op_t'(in_op);
    w_a_abs = in_a;
    w_b_abs = in_b;
`ifdef MULDIV_SIGNED_EN
    w_sign  = 1'b0;
    if (w_op == OP_RSVD) w_op = OP_MUL;
    if ((w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM)) begin
      w_sign = (w_op == OP_REM) ? in_a[WIDTH-1] : (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
      if (in_a[WIDTH-1]) w_a_abs = neg(in_a);
      if (in_b[WIDTH-1]) w_b_abs = neg(in_b);
    end
    w_ovf = ((w_op == OP_DIV) || (w_op == OP_REM)) && (in_a == DIV_OVF_Q) && (in_b == '1);
`else
    case (w_op)
      OP_MULH: w_op = OP_MULHU;
      OP_DIV:  w_op = OP_DIVU;
      OP_REM:  w_op = OP_REMU;
      OP_RSVD: w_op = OP_MUL;
      default: ;
    endcase
`endif
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_is_div   (w_is_div),
    .i_hi       (r_hi),
    .i_lo       (r_lo),
    .i_mcand    (r_mcand),
    .i_alu_out  (alu_out),
    .o_alu_op1  (w_step_op1),
    .o_alu_op2  (w_step_op2),
    .o_alu_ctrl (w_step_ctrl),
    .o_hi_nxt   (w_hi_nxt),
    .o_lo_nxt   (w_lo_nxt)
  );

  // Shared ALU is driven only while iterating or fixing the sign; idle value is 0 + 0.
  always_comb begin
    alu_op1  = '0;
    alu_op2  = '0;
    alu_ctrl = ALU_ADD;
    case (r_state)
      ST_ITER: begin
        alu_op1  = w_step_op1;
        alu_op2  = w_step_op2;
        alu_ctrl = w_step_ctrl;
      end
`ifdef MULDIV_SIGNED_EN
      ST_FIX: begin
        alu_op2  = op_sel_hi(r_op) ? r_hi : r_lo;
        alu_ctrl = ALU_SUB;
      end
`endif
      default: ;
    endcase
  end

  // Sequencer FSM: accept, iterate 32 times, optionally negate, then hold the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_MUL;
      r_cnt     <= '0;
      r_result  <= '0;
      r_divzero <= 1'b0;
`ifdef MULDIV_SIGNED_EN
      r_sign    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_op      <= w_op;
            r_cnt     <= '1;
            r_divzero <= 1'b0;
            r_hi      <= '0;
            r_lo      <= w_in_is_div ? w_a_abs : w_b_abs;
            r_mcand   <= w_in_is_div ? w_b_abs : w_a_abs;
`ifdef MULDIV_SIGNED_EN
            r_sign    <= w_sign;
`endif
            if (w_in_is_div && (in_b == '0)) begin
              r_result  <= op_is_rem(w_op) ? in_a : DIVZERO_Q;
              r_divzero <= 1'b1;
              r_state   <= ST_DONE;
`ifdef MULDIV_SIGNED_EN
            end else if (w_ovf) begin
              r_result  <= (w_op == OP_DIV) ? DIV_OVF_Q : '0;
              r_state   <= ST_DONE;
`endif
            end else begin
              r_state   <= ST_ITER;
            end
          end
        end
        ST_ITER: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
`ifdef MULDIV_SIGNED_EN
            if (r_sign) begin
              r_state <= ST_FIX;
            end else begin
              r_result <= op_sel_hi(r_op) ? w_hi_nxt : w_lo_nxt;
              r_state  <= ST_DONE;
            end
`else
            r_result <= op_sel_hi(r_op) ? w_hi_nxt : w_lo_nxt;
            r_state  <= ST_DONE;
`endif
          end
        end
`ifdef MULDIV_SIGNED_EN
        ST_FIX: begin
          // MULH negates the full 64-bit product: borrow reaches the high word only when L is zero.
          r_result <= (r_op == OP_MULH) ? (~r_hi + {{(WIDTH-1){1'b0}}, (r_lo == '0)}) : alu_out;
          r_state  <= ST_DONE;
        end
`endif
        ST_DONE: begin
          if (out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed testbench for muldiv_seq with a behavioural model of the shared ALU.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_divzero;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_out;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Shared ALU: 1000 subtracts, everything else used here adds.
  assign alu_out = (alu_ctrl == 4'b1000) ? (alu_op1 - alu_op2) : (alu_op1 + alu_op2);

  muldiv_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_divzero (out_divzero),
    .alu_op1     (alu_op1),
    .alu_op2     (alu_op2),
    .alu_ctrl    (alu_ctrl),
    .alu_out     (alu_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else begin
      failed = failed + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait for the result, check latency/result/flag, then accept it.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic exp_dz, input int exp_lat);
    int lat;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".result"}, out_result, exp_res);
    check({tag, ".divzero"}, {31'd0, out_divzero}, {31'd0, exp_dz});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".idle_after"}, {30'd0, in_ready, out_valid}, 32'h2);
  endtask

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_op     = 3'd0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_result", out_result, 32'd0);
    check("rst.out_divzero", {31'd0, out_divzero}, 32'd0);
    check("rst.alu_op1", alu_op1, 32'd0);
    check("rst.alu_op2", alu_op2, 32'd0);
    check("rst.alu_ctrl", {28'd0, alu_ctrl}, 32'd0);

    // Unsigned multiply / divide
    run_op("mul_ff",   3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33);
    run_op("mulhu_ff", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
    run_op("divu_100", 3'd2, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    run_op("remu_100", 3'd3, 32'd100,      32'd7,        32'd2,        1'b0, 33);
    run_op("divu_ff1", 3'd2, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 33);
    run_op("mul_rsvd", 3'd7, 32'd3,        32'd5,        32'd15,       1'b0, 33);

    // Divide by zero
    run_op("divu_z",   3'd2, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1);
    run_op("remu_z",   3'd3, 32'd5,        32'd0,        32'd5,        1'b1, 1);

`ifdef MULDIV_SIGNED_EN
    run_op("div_neg",  3'd5, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 34);
    run_op("rem_neg",  3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 34);
    run_op("mulh_m1",  3'd4, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 1'b0, 34);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);
    run_op("div_ovf",  3'd5, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
    run_op("div_z",    3'd5, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, 1);
`else
    run_op("div_as_u", 3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 1'b0, 33);
    run_op("rem_as_u", 3'd6, 32'hFFFFFFF9, 32'd2,        32'd1,        1'b0, 33);
    run_op("mulh_as_u",3'd4, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b0, 33);
    run_op("rem_8000", 3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 33);
`endif

    // Handshake: result held while out_ready is low, new request ignored meanwhile
    in_op = 3'd0; in_a = 32'd6; in_b = 32'd7; in_valid = 1'b1;
    tick();
    in_op = 3'd2; in_a = 32'd100; in_b = 32'd7;
    lat = 1;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    check("hs.latency", 32'(lat), 32'd33);
    for (int i = 0; i < 10; i++) begin
      check("hs.hold_valid", {31'd0, out_valid}, 32'd1);
      check("hs.hold_result", out_result, 32'd42);
      check("hs.hold_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs.after_valid", {31'd0, out_valid}, 32'd0);
    check("hs.after_in_ready", {31'd0, in_ready}, 32'd1);
    check("hs.after_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
    in_valid = 1'b0;
    run_op("hs.next", 3'd2, 32'd100, 32'd7, 32'd14, 1'b0, 33);

    // Reset during ITER aborts the op
    in_op = 3'd2; in_a = 32'd1000; in_b = 32'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("mid.busy", {31'd0, in_ready}, 32'd0);
    check("mid.alu_ctrl", {28'd0, alu_ctrl}, 32'h8);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid.in_ready", {31'd0, in_ready}, 32'd1);
    check("mid.out_valid", {31'd0, out_valid}, 32'd0);
    check("mid.out_result", out_result, 32'd0);
    check("mid.out_divzero", {31'd0, out_divzero}, 32'd0);
    check("mid.alu_op1", alu_op1, 32'd0);
    check("mid.alu_op2", alu_op2, 32'd0);
    check("mid.alu_ctrl0", {28'd0, alu_ctrl}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      if (out_valid) check("mid.spurious_valid", {31'd0, out_valid}, 32'd0);
      tick();
    end
    run_op("mid.fresh", 3'd0, 32'd3, 32'd5, 32'd15, 1'b0, 33);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
